serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that time-multiplexes a single one-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in. It sits between an upstream producer and a downstream consumer using valid/ready handshakes on both sides. It sequences the full-adder datapath LSB-first and holds a registered carry between bit steps. This trades area for latency in place of a WIDTH-wide ripple-carry adder.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 1 to 64.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  upstream offers operands.
- in_ready  output  1  controller can accept operands; high only in IDLE.
- a  input  WIDTH  operand A; sampled only on accept.
- b  input  WIDTH  operand B; sampled only on accept.
- cin  input  1  carry-in; sampled only on accept.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  downstream consumes the result.
- sum  output  WIDTH  registered A+B+cin, low WIDTH bits.
- cout  output  1  registered carry out of bit WIDTH-1.
- ovf  output  1  signed overflow. Present only with SERIAL_ADDER_OVF_EN.

## Operation
- States:
  - IDLE: reset state.
  - RUN: one bit computed per cycle.
  - DONE: result held.
- IDLE -> RUN on in_valid && in_ready:
  - Load a and b into internal shift registers.
  - Load cin into the carry register.
  - Clear the bit counter to 0.
- RUN, each edge:
  - The full-adder cell takes a_sh[0], b_sh[0] and carry.
  - The sum bit shifts into the MSB of the sum register, with a right shift.
  - The carry register takes the cell's carry-out.
  - a_sh and b_sh shift right.
  - The counter increments.
- RUN -> DONE on the edge where the counter equals WIDTH-1, i.e. after WIDTH RUN edges.
  - cout = final carry register.
- DONE -> IDLE on out_valid && out_ready.
  - No accept in the same cycle: in_ready is low in DONE.
- Inputs a, b, cin and in_valid are ignored outside IDLE.
- sum and cout:
  - Stable throughout DONE and IDLE until the next accept.
  - Contents during RUN are undefined to consumers.
- Counter width is clog2(WIDTH+1) bits; no wrap is reachable.
- WIDTH=1 is a legal case: exactly one RUN cycle.

## Timing
- Reset values: state IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; carry, shift registers and counter all 0.
- Reset asserted mid-RUN or in DONE:
  - Aborts immediately and asynchronously to the reset values.
  - No out_valid is produced for the aborted operation.
- Latency: out_valid rises WIDTH clock edges after the accept edge.
- Minimum period between accepts is WIDTH+2 cycles: WIDTH RUN cycles, 1 DONE cycle with out_ready high, and 1 IDLE cycle.
- Backpressure: with out_ready low, DONE is held indefinitely. sum, cout and ovf stay unchanged and in_ready stays low.
- in_ready and out_valid are decoded directly from the state register. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds port ovf and a one-bit register that captures the carry into bit WIDTH-1 on the last RUN edge.
  - ovf = captured carry XOR cout, registered, and valid in DONE.
- Undefined:
  - Port ovf and its register are absent.
  - All other behaviour and timing are identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0 -> out_valid exactly 8 edges after accept; sum=0x8D, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- Backpressure:
  - Stimulus: hold out_ready low for 5 cycles in DONE; pulse in_valid with new operands during RUN and DONE.
  - Required: sum and cout unchanged, in_ready=0, pulses ignored, one result delivered on out_ready.
- Reset mid-operation:
  - Stimulus: assert rst after 3 RUN edges.
  - Required: outputs take reset values without a clock edge and out_valid never rises. Next transaction a=0x01, b=0x02 -> sum=0x03.
- Back-to-back:
  - Stimulus: in_valid and out_ready held high.
  - Required: accepts spaced exactly WIDTH+2 cycles; each result matches a reference model over 1000 random operands.
- WIDTH=1 build: a=1, b=1, cin=1 -> one RUN cycle, sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB-first over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_reg;
    logic [WIDTH-1:0] a_sh_next, b_sh_next, sum_next;
    logic             carry_reg;
    logic             cout_reg;
    logic [CW-1:0]    cnt_reg;
    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_reg;
`endif

    assign accept   = (state_reg == IDLE) && bus.in_valid;
    assign last_bit = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));

    // The single shared full-adder cell.
    assign fa_s  = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
    assign fa_co = (a_sh_reg[0] & b_sh_reg[0]) | (carry_reg & (a_sh_reg[0] ^ b_sh_reg[0]));

    // Operands shift right; the new sum bit enters at the MSB so that after
    // WIDTH steps the LSB-first result lines up in sum_reg.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign a_sh_next[gi] = 1'b0;
                assign b_sh_next[gi] = 1'b0;
                assign sum_next[gi]  = fa_s;
            end else begin : g_body
                assign a_sh_next[gi] = a_sh_reg[gi+1];
                assign b_sh_next[gi] = b_sh_reg[gi+1];
                assign sum_next[gi]  = sum_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_bit)      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else if (accept) begin
            a_sh_reg  <= bus.a;
            b_sh_reg  <= bus.b;
            carry_reg <= bus.cin;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            sum_reg   <= sum_next;
            carry_reg <= fa_co;
            cnt_reg   <= cnt_reg + CW'(1);
            if (last_bit) begin
                cout_reg <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_reg here is the carry into the MSB.
                ovf_reg  <= carry_reg ^ fa_co;
`endif
            end
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and back-to-back random checks of serial_adder_ctrl (WIDTH=8 and WIDTH=1).
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                          input logic tc, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        bus.a = ta; bus.b = tbv; bus.cin = tc; bus.in_valid = 1'b1;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.a = ~ta; bus.b = ~tbv; bus.cin = ~tc;
        chk({tag, "_busy"}, bus.in_ready, 0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_sum"}, bus.sum, es);
        chk({tag, "_cout"}, bus.cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, bus.ovf, eo);
`else
        if (eo === 1'bx) $display("note: %s expected ovf unknown", tag);
`endif
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_consumed"}, bus.out_valid, 0);
        $display("txn %s: a=%h b=%h cin=%b sum=%h cout=%b", tag, ta, tbv, tc, bus.sum, bus.cout);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int       n;
        logic     saw;
        int       cyc, last_acc, nacc, nres;
        logic     accepting;
        logic [9:0] expq[$];
        logic [8:0] full;
        logic [9:0] e;

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 8'h00);
        chk("rst_cout", bus.cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", bus.ovf, 0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        do_txn("t1", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b1 ^ 1'b1, 1'b1);
        do_txn("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure with ignored pulses during RUN and DONE
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.a = 8'hF0; bus.b = 8'h0F; bus.cin = 1'b1;
            bus.in_valid = (i % 2 == 0);
            if (i == 3) chk("bp_run_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_done", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 1);
            tick();
            chk($sformatf("bp_hold%0d", i), {bus.out_valid, bus.in_ready, bus.cout, bus.sum}, {1'b1, 1'b0, 1'b0, 8'h46});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
        tick();
        chk("bp_no_extra", {bus.out_valid, bus.in_ready, bus.sum}, {1'b0, 1'b1, 8'h46});
        $display("txn bp: a=12 b=34 sum=%h cout=%b", bus.sum, bus.cout);

        do_txn("t3", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Reset mid-RUN, asynchronous
        bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_sum", bus.sum, 8'h00);
        chk("arst_cout", bus.cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("arst_ovf", bus.ovf, 0);
`endif
        tick();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) saw = 1'b1;
        end
        chk("arst_no_valid", saw, 0);
        $display("txn arst: aborted operation, out_valid seen=%b", saw);
        do_txn("t4", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Back-to-back random stream
        cyc = 0; last_acc = -1; nacc = 0; nres = 0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        while (nres < 1000 && cyc < 20000) begin
            accepting = 1'b0;
            if (bus.in_ready && bus.in_valid) begin
                full = {1'b0, bus.a} + {1'b0, bus.b} + {8'h00, bus.cin};
                e = {(bus.a[7] == bus.b[7]) && (full[7] != bus.a[7]), full};
                expq.push_back(e);
                if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 10);
                last_acc = cyc;
                nacc++;
                accepting = 1'b1;
            end
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk("b2b_unexpected", 1, 0);
                end else begin
                    e = expq.pop_front();
`ifdef SERIAL_ADDER_OVF_EN
                    chk("b2b_result", {bus.ovf, bus.cout, bus.sum}, e);
`else
                    chk("b2b_result", {bus.cout, bus.sum}, e[8:0]);
`endif
                    if (nres % 100 == 0)
                        $display("txn b2b%0d: sum=%h cout=%b exp=%h", nres, bus.sum, bus.cout, e[8:0]);
                end
                nres++;
            end
            tick();
            cyc++;
            if (accepting) begin
                bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
                if (nacc >= 1000) bus.in_valid = 1'b0;
            end
        end
        chk("b2b_count", nres, 1000);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick();

        // WIDTH=1 instance
        chk("w1_idle", {bus1.in_ready, bus1.out_valid}, 2'b10);
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk("w1_run", bus1.out_valid, 0);
        tick();
        chk("w1_done", bus1.out_valid, 1);
        chk("w1_result", {bus1.cout, bus1.sum}, 2'b11);
`ifdef SERIAL_ADDER_OVF_EN
        chk("w1_ovf", bus1.ovf, 0);
`endif
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        chk("w1_consumed", {bus1.in_ready, bus1.out_valid}, 2'b10);
        $display("txn w1: a=1 b=1 cin=1 sum=%b cout=%b", bus1.sum, bus1.cout);

        n = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
